// File: rtl/genie_split.sv
// genie_split: packet-aware valid/ready splitter. Each input beat is offered
// to every output selected by the packet's destination mask and retires once
// all selected outputs have accepted it. The mask is taken from i_mask on the
// first beat of a packet and held for the remaining beats.
//
// Optional feature: define GENIE_SPLIT_DROP_COUNT_EN to enable a saturating
// 16-bit counter of packets dropped because of an all-zero destination mask.
// Without the macro o_drop_count is tied to zero and no counter exists.
module genie_split #(
    parameter int unsigned NO    = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [((WIDTH > 0) ? WIDTH : 1)-1:0]  i_data,
    input  logic                                  i_valid,
    input  logic                                  i_eop,
    input  logic [NO-1:0]                         i_mask,
    output logic                                  o_ready,
    output logic [((WIDTH > 0) ? WIDTH : 1)-1:0]  o_data,
    output logic                                  o_eop,
    output logic [NO-1:0]                         o_valid,
    input  logic [NO-1:0]                         i_ready,
    output logic [15:0]                           o_drop_count
);

    localparam int unsigned DW = (WIDTH > 0) ? WIDTH : 1;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [NO-1:0]   mask_q;
    logic [NO-1:0]   done;
    logic [NO-1:0]   active_mask;
    logic [NO-1:0]   accept;
    logic            retire;
    logic            first_beat;

    // Destination selection: live mask on the first beat, latched mask after.
    always_comb begin
        first_beat  = (state == S_FIRST);
        active_mask = first_beat ? i_mask : mask_q;
        o_valid     = {NO{i_valid & ~reset}} & active_mask & ~done;
        accept      = o_valid & i_ready;
        retire      = &(~active_mask | done | accept);
        o_ready     = i_valid & retire & ~reset;
    end

    // Data and eop are broadcast unregistered to every output.
    generate
        if (WIDTH > 0) begin : g_data
            assign o_data = i_data;
        end else begin : g_nodata
            assign o_data = DW'(0);
        end
    endgenerate

    assign o_eop = i_eop;

    // Packet state, mask latch and per-output acceptance tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FIRST;
            mask_q <= '0;
            done   <= '0;
        end else if (o_ready) begin
            done <= '0;
            case (state)
                S_FIRST: begin
                    if (!i_eop) begin
                        state  <= S_LOCKED;
                        mask_q <= i_mask;
                    end
                end
                S_LOCKED: begin
                    if (i_eop) begin
                        state <= S_FIRST;
                    end
                end
                default: state <= S_FIRST;
            endcase
        end else begin
            // Partial acceptance accumulates; a dropped i_valid holds done.
            done <= done | accept;
        end
    end

`ifdef GENIE_SPLIT_DROP_COUNT_EN
    logic [15:0] drop_q;

    // Count packets whose first beat retires with no destination selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 16'd0;
        end else if (o_ready && first_beat && (active_mask == '0) &&
                     (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign o_drop_count = drop_q;
`else
    assign o_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_genie_split.sv
// Self-checking bench for genie_split (NO=3, WIDTH=8): directed scenarios
// followed by constrained-random traffic, all compared against a
// packet-level reference model.
module tb_genie_split;

    localparam int unsigned NO = 3;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  i_data;
    logic          i_valid;
    logic          i_eop;
    logic [NO-1:0] i_mask;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic          o_eop;
    logic [NO-1:0] o_valid;
    logic [NO-1:0] i_ready;
    logic [15:0]   o_drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: packet position, locked destination set, outputs
    // that already hold the current beat, and dropped-packet tally.
    bit            m_in_packet = 1'b0;
    bit [NO-1:0]   m_dest      = '0;
    bit [NO-1:0]   m_taken     = '0;
    int            m_drops     = 0;

    genie_split #(.NO(NO), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_eop        (i_eop),
        .i_mask       (i_mask),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_eop        (o_eop),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, check outputs,
    // then advance the model across the rising edge.
    task automatic step(input logic v, input logic e, input logic [NO-1:0] m,
                        input logic [NO-1:0] r, input logic [W-1:0] d,
                        input logic rst, output logic [NO-1:0] obs_valid,
                        output logic obs_ready);
        bit [NO-1:0] dest;
        bit [NO-1:0] pend;
        bit [NO-1:0] exp_v;
        bit          exp_r;
        int          exp_drop;
        reset   = rst;
        i_valid = v;
        i_eop   = e;
        i_mask  = m;
        i_ready = r;
        i_data  = d;
        #1;
        dest  = m_in_packet ? m_dest : m;
        pend  = dest & ~m_taken;
        exp_v = (v && !rst) ? pend : '0;
        exp_r = v && !rst && ((pend & ~r) == '0);
`ifdef GENIE_SPLIT_DROP_COUNT_EN
        exp_drop = m_drops;
`else
        exp_drop = 0;
`endif
        check("o_valid", 32'(o_valid), 32'(exp_v));
        check("o_ready", 32'(o_ready), 32'(exp_r));
        check("o_data", 32'(o_data), 32'(d));
        check("o_eop", 32'(o_eop), 32'(e));
        check("o_drop_count", 32'(o_drop_count), 32'(exp_drop));
        obs_valid = o_valid;
        obs_ready = o_ready;
        @(posedge clk);
        if (rst) begin
            m_in_packet = 1'b0;
            m_taken     = '0;
        end else if (exp_r) begin
            m_taken = '0;
            if (!m_in_packet) begin
                if (dest == '0 && m_drops < 65535) m_drops++;
                if (!e) begin
                    m_in_packet = 1'b1;
                    m_dest      = m;
                end
            end else if (e) begin
                m_in_packet = 1'b0;
            end
        end else begin
            m_taken = m_taken | (exp_v & r);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NO-1:0] ov;
        logic          ordy;
        bit            have_beat;
        bit            cur_e;
        logic [NO-1:0] cur_m;
        logic [W-1:0]  cur_d;

        reset = 1'b1; i_valid = 1'b0; i_eop = 1'b0; i_mask = '0;
        i_ready = '0; i_data = '0;
        @(negedge clk);

        // Reset state: nothing offered, nothing retired, even with demand.
        step(1'b1, 1'b1, 3'b111, 3'b111, 8'h11, 1'b1, ov, ordy);
        check("reset_valid", 32'(ov), 32'(0));
        check("reset_ready", 32'(ordy), 32'(0));

        // Single-beat packet, all selected outputs ready at once.
        step(1'b1, 1'b1, 3'b101, 3'b101, 8'hA5, 1'b0, ov, ordy);
        check("single_valid", 32'(ov), 32'(3'b101));
        check("single_ready", 32'(ordy), 32'(1));

        // Staggered acceptance: 111 -> 110 -> 010 -> 010, retire at cycle 3.
        step(1'b1, 1'b1, 3'b111, 3'b001, 8'h3C, 1'b0, ov, ordy);
        check("stag0_valid", 32'(ov), 32'(3'b111));
        check("stag0_ready", 32'(ordy), 32'(0));
        step(1'b1, 1'b1, 3'b111, 3'b100, 8'h3C, 1'b0, ov, ordy);
        check("stag1_valid", 32'(ov), 32'(3'b110));
        step(1'b1, 1'b1, 3'b111, 3'b000, 8'h3C, 1'b0, ov, ordy);
        check("stag2_valid", 32'(ov), 32'(3'b010));
        step(1'b1, 1'b1, 3'b111, 3'b111, 8'h3C, 1'b0, ov, ordy);
        check("stag3_valid", 32'(ov), 32'(3'b010));
        check("stag3_ready", 32'(ordy), 32'(1));
        step(1'b0, 1'b0, 3'b000, 3'b111, 8'h00, 1'b0, ov, ordy);
        check("stag4_valid", 32'(ov), 32'(0));

        // Four-beat packet: mask locked from the first beat despite changes.
        step(1'b1, 1'b0, 3'b010, 3'b111, 8'h01, 1'b0, ov, ordy);
        for (int b = 1; b < 4; b++) begin
            step(1'b1, (b == 3), 3'b001, 3'b111, 8'(b), 1'b0, ov, ordy);
            check("locked_valid", 32'(ov), 32'(3'b010));
        end
        // Back at a first beat: the new mask applies.
        step(1'b1, 1'b1, 3'b100, 3'b111, 8'h55, 1'b0, ov, ordy);
        check("after_eop_valid", 32'(ov), 32'(3'b100));

        // Zero-mask two-beat packet: dropped, counted once.
        step(1'b1, 1'b0, 3'b000, 3'b000, 8'hD0, 1'b0, ov, ordy);
        check("drop0_ready", 32'(ordy), 32'(1));
        step(1'b1, 1'b1, 3'b111, 3'b000, 8'hD1, 1'b0, ov, ordy);
        check("drop1_valid", 32'(ov), 32'(0));
        step(1'b0, 1'b0, 3'b000, 3'b000, 8'h00, 1'b0, ov, ordy);

        // Upstream drops valid mid-beat: partial acceptance is held.
        step(1'b1, 1'b1, 3'b011, 3'b001, 8'h77, 1'b0, ov, ordy);
        step(1'b0, 1'b1, 3'b011, 3'b000, 8'h77, 1'b0, ov, ordy);
        step(1'b1, 1'b1, 3'b011, 3'b011, 8'h77, 1'b0, ov, ordy);
        check("held_done_valid", 32'(ov), 32'(3'b010));

        // Reset mid-packet with output 0 already done: packet aborted.
        step(1'b1, 1'b0, 3'b011, 3'b011, 8'h90, 1'b0, ov, ordy);
        step(1'b1, 1'b0, 3'b101, 3'b001, 8'h91, 1'b0, ov, ordy);
        step(1'b1, 1'b0, 3'b101, 3'b000, 8'h91, 1'b1, ov, ordy);
        step(1'b1, 1'b1, 3'b110, 3'b000, 8'h92, 1'b0, ov, ordy);
        check("post_reset_valid", 32'(ov), 32'(3'b110));
        step(1'b1, 1'b1, 3'b110, 3'b110, 8'h92, 1'b0, ov, ordy);

        // Random traffic obeying the upstream hold rule.
        have_beat = 1'b0; cur_e = 1'b0; cur_m = '0; cur_d = '0;
        for (int c = 0; c < 600; c++) begin
            if (!have_beat && ($urandom_range(9) < 7)) begin
                have_beat = 1'b1;
                cur_e     = ($urandom_range(9) < 4);
                cur_m     = NO'($urandom);
                cur_d     = W'($urandom);
            end
            step(have_beat, cur_e, cur_m, NO'($urandom), cur_d,
                 ($urandom_range(99) == 0), ov, ordy);
            if (ordy || reset) have_beat = 1'b0;
        end

`ifdef GENIE_SPLIT_DROP_COUNT_EN
        // Drive the drop counter into saturation and past it.
        step(1'b0, 1'b0, 3'b000, 3'b000, 8'h00, 1'b1, ov, ordy);
        m_drops = 0;
        for (int k = 0; k < 65540; k++) begin
            step(1'b1, 1'b1, 3'b000, 3'b000, 8'h00, 1'b0, ov, ordy);
        end
        step(1'b0, 1'b0, 3'b000, 3'b000, 8'h00, 1'b0, ov, ordy);
        check("drop_saturated", 32'(o_drop_count), 32'h0000FFFF);
`else
        step(1'b1, 1'b1, 3'b000, 3'b000, 8'h00, 1'b0, ov, ordy);
        step(1'b0, 1'b0, 3'b000, 3'b000, 8'h00, 1'b0, ov, ordy);
        check("drop_tied_zero", 32'(o_drop_count), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
